// File: rtl/rv32imf_pkg.sv
// Shared types and defaults for the rv32imf clock-gating controller.
package rv32imf_pkg;

  localparam int unsigned CG_IDLE_CYCLES_DEFAULT = 4;
  localparam int unsigned CG_NUM_WAKE_DEFAULT    = 4;

  typedef enum logic [1:0] {
    CG_RUN   = 2'd0,
    CG_DRAIN = 2'd1,
    CG_HOLD  = 2'd2,
    CG_SLEEP = 2'd3
  } cg_state_e;

endpackage

// File: rtl/rv32imf_clock_gate.sv
// Glitch-free clock gate: the enable is registered on the rising edge, then
// re-timed on the falling edge so it only changes while clk_i is low.
module rv32imf_clock_gate (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic clk_o
);

  logic en_d, en_q;
  logic en_neg_d, en_neg_q;

  // Next-value selection for both enable stages.
  always_comb begin
    en_d     = en_i;
    en_neg_d = en_q;
  end

  // Rising-edge enable register; reset keeps the clock running.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) en_q <= 1'b1;
    else       en_q <= en_d;
  end

  // Falling-edge stage so the AND below never sees an enable change while clk_i is high.
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) en_neg_q <= 1'b1;
    else       en_neg_q <= en_neg_d;
  end

  assign clk_o = clk_i & en_neg_q;

endmodule

// File: rtl/rv32imf_clk_gate_ctrl.sv
// Core clock-gating controller: RUN -> DRAIN -> HOLD -> SLEEP sequencing on the
// ungated clock, wake-cause latching and a gated clock output.
// Optional sleep-cycle statistics counter: define RV32IMF_CLK_GATE_STATS_EN.
import rv32imf_pkg::*;

module rv32imf_clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = CG_IDLE_CYCLES_DEFAULT,
  parameter int unsigned NUM_WAKE    = CG_NUM_WAKE_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                sleep_req_i,
  input  logic                core_busy_i,
  input  logic [NUM_WAKE-1:0] wake_i,
  input  logic [NUM_WAKE-1:0] wake_mask_i,
  input  logic                force_on_i,
  output logic                clk_en_o,
  output logic                clk_gated_o,
  output logic                sleep_ack_o,
  output logic [NUM_WAKE-1:0] wake_src_o,
  output logic [1:0]          state_o,
  output logic [31:0]         sleep_cnt_o
);

  localparam logic [7:0] HOLD_LOAD = 8'(IDLE_CYCLES - 1);

  cg_state_e           state_d, state_q;
  logic [7:0]          hold_cnt_d, hold_cnt_q;
  logic                clk_en_d, clk_en_q;
  logic [NUM_WAKE-1:0] wake_src_d, wake_src_q;
  logic [NUM_WAKE-1:0] wake_hit, wake_first;
  logic                wake_any, abort;

  // Wake qualification; x & -x isolates the lowest asserted source.
  always_comb begin
    wake_hit   = wake_i & wake_mask_i;
    wake_first = wake_hit & (~wake_hit + NUM_WAKE'(1));
    wake_any   = (|wake_hit) | force_on_i;
    abort      = wake_any | ~sleep_req_i;
  end

  // Next-state, hold counter and wake-cause capture.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    wake_src_d = wake_src_q;
    clk_en_d   = (state_q != CG_SLEEP);
    unique case (state_q)
      CG_RUN: begin
        if (sleep_req_i && !wake_any) state_d = CG_DRAIN;
      end
      CG_DRAIN: begin
        if (abort) begin
          state_d = CG_RUN;
        end else if (!core_busy_i) begin
          state_d    = CG_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end
      end
      CG_HOLD: begin
        if (abort)                    state_d    = CG_RUN;
        else if (hold_cnt_q == '0)    state_d    = CG_SLEEP;
        else                          hold_cnt_d = hold_cnt_q - 8'd1;
      end
      CG_SLEEP: begin
        if (wake_any) begin
          state_d    = CG_RUN;
          wake_src_d = wake_first;
        end
      end
      default: state_d = CG_RUN;
    endcase
  end

  // Controller state registers on the free-running clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= CG_RUN;
      hold_cnt_q <= '0;
      clk_en_q   <= 1'b1;
      wake_src_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      clk_en_q   <= clk_en_d;
      wake_src_q <= wake_src_d;
    end
  end

`ifdef RV32IMF_CLK_GATE_STATS_EN
  logic [31:0] sleep_cnt_d, sleep_cnt_q;

  // Saturating count of cycles spent in SLEEP.
  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (state_q == CG_SLEEP && sleep_cnt_q != '1) sleep_cnt_d = sleep_cnt_q + 32'd1;
  end

  // Statistics register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sleep_cnt_q <= '0;
    else       sleep_cnt_q <= sleep_cnt_d;
  end

  assign sleep_cnt_o = sleep_cnt_q;
`else
  assign sleep_cnt_o = '0;
`endif

  assign clk_en_o    = clk_en_q;
  assign sleep_ack_o = (state_q == CG_SLEEP);
  assign wake_src_o  = wake_src_q;
  assign state_o     = state_q;

  rv32imf_clock_gate u_clock_gate (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (clk_en_q),
    .clk_o (clk_gated_o)
  );

endmodule

// File: tb/tb_rv32imf_clk_gate_ctrl.sv
// Scoreboard bench for rv32imf_clk_gate_ctrl: stimulus queues expected output
// values tagged with a cycle number; a monitor compares them at each falling edge.
module tb_rv32imf_clk_gate_ctrl;

`ifdef RV32IMF_CLK_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int S_STATE = 0;
  localparam int S_EN    = 1;
  localparam int S_ACK   = 2;
  localparam int S_WSRC  = 3;
  localparam int S_CNT   = 4;
  localparam int S_GATED = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sleep_req = 1'b0;
  logic        core_busy = 1'b0;
  logic [3:0]  wake = '0;
  logic [3:0]  wake_mask = '0;
  logic        force_on = 1'b0;
  logic        clk_en, clk_gated, sleep_ack;
  logic [3:0]  wake_src;
  logic [1:0]  state;
  logic [31:0] sleep_cnt;

  int          cyc = 0;
  logic        gated_hi = 1'b0;
  int          checks = 0;
  int          errors = 0;

  int          q_cyc[$];
  int          q_sel[$];
  logic [31:0] q_val[$];
  string       q_name[$];

  rv32imf_clk_gate_ctrl #(.IDLE_CYCLES(4), .NUM_WAKE(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .sleep_req_i (sleep_req),
    .core_busy_i (core_busy),
    .wake_i      (wake),
    .wake_mask_i (wake_mask),
    .force_on_i  (force_on),
    .clk_en_o    (clk_en),
    .clk_gated_o (clk_gated),
    .sleep_ack_o (sleep_ack),
    .wake_src_o  (wake_src),
    .state_o     (state),
    .sleep_cnt_o (sleep_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gated clock sampled inside the high phase.
  always @(posedge clk) begin
    #2;
    gated_hi = clk_gated;
  end

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_STATE: return {30'd0, state};
      S_EN:    return {31'd0, clk_en};
      S_ACK:   return {31'd0, sleep_ack};
      S_WSRC:  return {28'd0, wake_src};
      S_CNT:   return sleep_cnt;
      default: return {31'd0, gated_hi};
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle.
  always @(negedge clk) begin
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      logic [31:0] a;
      a = actual(q_sel[0]);
      checks++;
      if (a !== q_val[0]) begin
        errors++;
        $display("FAIL %s cyc=%0d actual=%0h expected=%0h", q_name[0], cyc, a, q_val[0]);
      end
      void'(q_cyc.pop_front());
      void'(q_sel.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
  end

  task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string name);
    q_cyc.push_back(c);
    q_sel.push_back(sel);
    q_val.push_back(v);
    q_name.push_back(name);
  endtask

  task automatic wait_to(input int n);
    while (cyc != n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int k, m, p, q, r;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL init_state actual=%0h expected=0", state);
    end
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL init_clk_en actual=%0h expected=1", clk_en);
    end

    // Reset state, then full sleep entry and masked wake exit.
    k = cyc;
    expect_at(k,      S_STATE, 0, "rst_state");
    expect_at(k,      S_EN,    1, "rst_clk_en");
    expect_at(k,      S_ACK,   0, "rst_ack");
    expect_at(k,      S_WSRC,  0, "rst_wake_src");
    expect_at(k,      S_CNT,   0, "rst_cnt");
    expect_at(k,      S_GATED, 1, "run_gated");
    expect_at(k + 1,  S_STATE, 1, "a_drain");
    expect_at(k + 2,  S_STATE, 2, "a_hold");
    expect_at(k + 5,  S_STATE, 2, "a_hold_last");
    expect_at(k + 6,  S_STATE, 3, "a_sleep");
    expect_at(k + 6,  S_ACK,   1, "a_ack");
    expect_at(k + 6,  S_EN,    1, "a_en_lag");
    expect_at(k + 7,  S_EN,    0, "a_en_off");
    expect_at(k + 9,  S_GATED, 0, "a_gated_flat0");
    expect_at(k + 10, S_GATED, 0, "a_gated_flat1");
    expect_at(k + 11, S_GATED, 0, "a_gated_flat2");
    expect_at(k + 26, S_STATE, 3, "a_sleep_ignores_req");
    expect_at(k + 26, S_CNT,   STATS ? 32'd20 : 32'd0, "a_cnt20");
    expect_at(k + 27, S_STATE, 0, "a_wake_run");
    expect_at(k + 27, S_WSRC,  4'b1000, "a_wake_src");
    expect_at(k + 27, S_EN,    0, "a_en_still_off");
    expect_at(k + 27, S_ACK,   0, "a_ack_clr");
    expect_at(k + 27, S_CNT,   STATS ? 32'd21 : 32'd0, "a_cnt21");
    expect_at(k + 28, S_EN,    1, "a_en_on");
    expect_at(k + 28, S_STATE, 0, "a_run_stay");
    sleep_req = 1'b1; wake_mask = 4'b1111;
    wait_to(k + 10); sleep_req = 1'b0;
    wait_to(k + 26); wake = 4'b1010; wake_mask = 4'b1000;
    wait_to(k + 27); wake = '0; wake_mask = '0;

    // Busy stall in DRAIN, then wake abort from HOLD.
    m = k + 30;
    expect_at(m + 1,  S_STATE, 1, "b_drain");
    expect_at(m + 5,  S_STATE, 1, "b_drain_busy");
    expect_at(m + 10, S_STATE, 1, "b_drain_10");
    expect_at(m + 11, S_STATE, 2, "b_hold");
    expect_at(m + 13, S_STATE, 0, "b_abort_run");
    expect_at(m + 14, S_STATE, 0, "b_run_stay");
    expect_at(m + 14, S_CNT,   STATS ? 32'd21 : 32'd0, "b_cnt_same");
    expect_at(m + 14, S_WSRC,  4'b1000, "b_wsrc_held");
    expect_at(m + 14, S_ACK,   0, "b_no_ack");
    wait_to(m); sleep_req = 1'b1; core_busy = 1'b1; wake_mask = 4'b0001;
    wait_to(m + 10); core_busy = 1'b0;
    wait_to(m + 12); wake = 4'b0001;
    wait_to(m + 13); wake = '0; sleep_req = 1'b0;

    // Request with wake pending, force_on override, request drop in DRAIN.
    p = m + 16;
    expect_at(p + 1, S_STATE, 0, "c_req_wake_run");
    expect_at(p + 2, S_STATE, 0, "c_req_wake_run2");
    expect_at(p + 3, S_STATE, 0, "c_force_run");
    expect_at(p + 4, S_STATE, 0, "c_force_run2");
    expect_at(p + 5, S_STATE, 1, "c_drain");
    expect_at(p + 6, S_STATE, 1, "c_drain2");
    expect_at(p + 7, S_STATE, 0, "c_req_drop_run");
    wait_to(p); sleep_req = 1'b1; wake = 4'b0001; wake_mask = 4'b0001;
    wait_to(p + 2); wake = '0; force_on = 1'b1;
    wait_to(p + 4); force_on = 1'b0; core_busy = 1'b1;
    wait_to(p + 6); sleep_req = 1'b0;
    wait_to(p + 7); core_busy = 1'b0;

    // Masked-off wake ignored in SLEEP; exit by force_on alone.
    q = p + 10;
    expect_at(q + 6, S_STATE, 3, "d_sleep");
    expect_at(q + 8, S_STATE, 3, "d_masked_ignored");
    expect_at(q + 9, S_STATE, 0, "d_force_exit");
    expect_at(q + 9, S_WSRC,  0, "d_wsrc_zero");
    expect_at(q + 9, S_CNT,   STATS ? 32'd24 : 32'd0, "d_cnt24");
    wait_to(q); sleep_req = 1'b1; wake = '0; wake_mask = '0;
    wait_to(q + 6); wake = 4'b0001; sleep_req = 1'b0;
    wait_to(q + 8); force_on = 1'b1;
    wait_to(q + 9); force_on = 1'b0; wake = '0;

    // Lowest-index wake cause, re-entry, then async reset pulse mid-SLEEP.
    r = q + 12;
    expect_at(r + 6,  S_STATE, 3, "e_sleep");
    expect_at(r + 7,  S_STATE, 0, "e_wake_run");
    expect_at(r + 7,  S_WSRC,  4'b0010, "e_wsrc_lowest");
    expect_at(r + 13, S_STATE, 3, "e_sleep2");
    expect_at(r + 14, S_EN,    0, "e_en_off");
    expect_at(r + 14, S_CNT,   STATS ? 32'd26 : 32'd0, "e_cnt26");
    expect_at(r + 15, S_STATE, 0, "e_rst_state");
    expect_at(r + 15, S_EN,    1, "e_rst_en");
    expect_at(r + 15, S_ACK,   0, "e_rst_ack");
    expect_at(r + 15, S_WSRC,  0, "e_rst_wsrc");
    expect_at(r + 15, S_CNT,   0, "e_rst_cnt");
    expect_at(r + 16, S_STATE, 0, "e_post_rst_state");
    expect_at(r + 16, S_GATED, 1, "e_post_rst_gated");
    wait_to(r); sleep_req = 1'b1; wake_mask = 4'b1111;
    wait_to(r + 6); wake = 4'b0110;
    wait_to(r + 7); wake = '0;
    wait_to(r + 15); sleep_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL async_rst_state actual=%0h expected=0", state);
    end
    checks++;
    if (clk_en !== 1'b1) begin
      errors++;
      $display("FAIL async_rst_clk_en actual=%0h expected=1", clk_en);
    end
    checks++;
    if (sleep_cnt !== 32'd0) begin
      errors++;
      $display("FAIL async_rst_cnt actual=%0h expected=0", sleep_cnt);
    end
    checks++;
    if (sleep_ack !== 1'b0) begin
      errors++;
      $display("FAIL async_rst_ack actual=%0h expected=0", sleep_ack);
    end
    rst = 1'b0;
    wait_to(r + 16);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 20 && q_cyc.size() > 0; i++) @(negedge clk);
    #1;
    while (q_cyc.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=none expected=%0h", q_name[0], q_val[0]);
      void'(q_cyc.pop_front());
      void'(q_sel.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32imf_clk_gate_ctrl.md
RV32IMF_CLK_GATE_CTRL -- requirements
Module: rv32imf_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYCLES, default 4, hold cycles between drain complete and gating (range 1..255).
REQ-002 SHALL have parameter NUM_WAKE, default 4, number of wake sources (range 1..16).
REQ-003 SHALL have port clk_i  input  1  free-running core clock; one clock only.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sleep_req_i  input  1  core sleep request (WFI), level.
REQ-006 SHALL have port core_busy_i  input  1  core has outstanding transactions.
REQ-007 SHALL have port wake_i  input  NUM_WAKE  wake events (irq, debug, ...), level.
REQ-008 SHALL have port wake_mask_i  input  NUM_WAKE  1 = source enabled.
REQ-009 SHALL have port force_on_i  input  1  test/debug override, keeps clock running.
REQ-010 SHALL have port clk_en_o  output  1  registered enable to clock gate.
REQ-011 SHALL have port clk_gated_o  output  1  gated core clock.
REQ-012 SHALL have port sleep_ack_o  output  1  high while in SLEEP.
REQ-013 SHALL have port wake_src_o  output  NUM_WAKE  one-hot latched wake cause.
REQ-014 SHALL have port state_o  output  2  current FSM state encoding.
REQ-015 SHALL have port sleep_cnt_o  output  32  sleep-cycle count (see Configuration).

Function
REQ-016 SHALL implement FSM RUN(0), DRAIN(1), HOLD(2), SLEEP(3), all on clk_i (ungated).
REQ-017 SHALL define wake_any = |(wake_i & wake_mask_i) | force_on_i.
REQ-018 SHALL move RUN->DRAIN when sleep_req_i & ~wake_any; else stay RUN.
REQ-019 SHALL move DRAIN->HOLD when ~core_busy_i, loading hold counter with IDLE_CYCLES-1.
REQ-020 SHALL decrement hold counter each HOLD cycle; move HOLD->SLEEP when counter == 0 in that cycle.
REQ-021 SHALL abort DRAIN or HOLD to RUN when wake_any or ~sleep_req_i; abort has priority over forward transitions.
REQ-022 SHALL move SLEEP->RUN when wake_any; sleep_req_i is ignored in SLEEP.
REQ-023 SHALL drive clk_en_o = 0 only when registered state is SLEEP; 1 otherwise (one-cycle latency from state entry).
REQ-024 SHALL drive sleep_ack_o = 1 exactly when state is SLEEP.
REQ-025 SHALL latch wake_src_o on SLEEP->RUN with lowest-index asserted masked wake bit (one-hot); all-zero if exit caused by force_on_i alone; hold until next SLEEP->RUN.
REQ-026 SHALL produce clk_gated_o through the glitch-free gate sub-module; gate adds its own one-cycle enable register.
REQ-027 SHALL, with simultaneous wake and sleep_req_i in RUN, stay in RUN.

Reset
REQ-028 SHALL, on rst_i assertion at any time (including SLEEP), asynchronously force state RUN, hold counter 0, clk_en_o 1, sleep_ack_o 0, wake_src_o 0, sleep_cnt_o 0.
REQ-029 SHALL resume normal sequencing on the first clk_i edge after rst_i deasserts.

Configuration
REQ-030 SHALL, with RV32IMF_CLK_GATE_STATS_EN defined, increment sleep_cnt_o by 1 each cycle in SLEEP, saturating at 0xFFFF_FFFF.
REQ-031 SHALL, without RV32IMF_CLK_GATE_STATS_EN, tie sleep_cnt_o to 0 and omit the counter logic.

Structure
REQ-032 SHALL place state typedef cg_state_e and constants CG_IDLE_CYCLES_DEFAULT, CG_NUM_WAKE_DEFAULT in rv32imf_pkg.
REQ-033 SHALL instantiate exactly one sub-module, rv32imf_clock_gate, driven by clk_i and clk_en_o.

Verification
REQ-034 SHALL cover: sleep_req_i=1, core_busy_i=0, IDLE_CYCLES=4, no wake -> DRAIN at cycle 1, HOLD at 2, SLEEP at 6, clk_en_o=0 at 7, clk_gated_o flat afterwards.
REQ-035 SHALL cover: in SLEEP, wake_i=4'b1010, wake_mask_i=4'b1000 -> RUN next cycle, wake_src_o=4'b1000, clk_en_o=1 one cycle later.
REQ-036 SHALL cover: core_busy_i=1 for 10 cycles during DRAIN -> state stays DRAIN 10 cycles, then HOLD.
REQ-037 SHALL cover: wake_i[0]=1 (masked on) during HOLD counter=2 -> RUN next cycle, SLEEP never entered, sleep_cnt_o unchanged.
REQ-038 SHALL cover: rst_i pulse mid-SLEEP between clk_i edges -> state_o=0, clk_en_o=1 immediately, sleep_cnt_o=0.
REQ-039 SHALL cover: with STATS_EN, 20 SLEEP cycles -> sleep_cnt_o=20; without STATS_EN -> sleep_cnt_o=0.
